// File: rtl/int_ctrl_if.sv
// rtl/int_ctrl_if.sv - signal bundle between int_ctrl and the CP0/pipeline side
//
// Purpose: carries interrupt inputs, STATUS fields, CP0 timer writes, the
// WB-stage handshake and the timer/pending outputs of int_ctrl.
// Modports:
//   slave  - int_ctrl side (consumes inputs, drives count/compare/ip/ti/int_req/int_take)
//   master - pipeline/CP0 side (the mirror image)
interface int_ctrl_if;
  logic [5:0]  hw_int;
  logic [1:0]  sw_int;
  logic [7:0]  status_im;
  logic        status_ie;
  logic        status_exl;
  logic        count_wen;
  logic        compare_wen;
  logic [31:0] cp0_wdata;
  logic        wb_valid;
  logic        wb_exc;
  logic [31:0] count;
  logic [31:0] compare;
  logic [7:0]  ip;
  logic        ti;
  logic        int_req;
  logic        int_take;

  modport slave (
    input  hw_int, sw_int, status_im, status_ie, status_exl,
    input  count_wen, compare_wen, cp0_wdata, wb_valid, wb_exc,
    output count, compare, ip, ti, int_req, int_take
  );

  modport master (
    output hw_int, sw_int, status_im, status_ie, status_exl,
    output count_wen, compare_wen, cp0_wdata, wb_valid, wb_exc,
    input  count, compare, ip, ti, int_req, int_take
  );
endinterface

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - CP0 Count/Compare timer and interrupt arbitration
//
// Purpose: synchronizes hardware interrupt lines, maintains Count/Compare and
// the timer interrupt flag, builds CAUSE.IP pending bits, and decides when an
// instruction in WB takes an interrupt.
// Ports:
//   clk   - single clock, rising edge
//   reset - synchronous, active-high
//   bus   - int_ctrl_if.slave: hw_int, sw_int, status_im/ie/exl, count_wen,
//           compare_wen, cp0_wdata, wb_valid, wb_exc in; count, compare, ip,
//           ti, int_req, int_take out
module int_ctrl (
  input  logic       clk,
  input  logic       reset,
  int_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    TAKEN = 2'd2
  } state_t;

  state_t      state_q;

  logic [5:0]  sync1_q, sync1_d;
  logic [5:0]  sync2_q, sync2_d;
  logic [7:0]  ip_q, ip_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        phase_q, phase_d;
  logic        ti_q, ti_d;

  logic        pend;
  logic        take;

  // Datapath next-state
  always_comb begin
    sync1_d   = bus.hw_int;
    sync2_d   = sync1_q;
    // Timer interrupt shares IP7 with hardware line 5
    ip_d      = {sync2_q[5] | ti_q, sync2_q[4:0], bus.sw_int};

    count_d   = count_q;
    phase_d   = ~phase_q;
    if (bus.count_wen) begin
      // A software write restarts the divide-by-two phase
      count_d = bus.cp0_wdata;
      phase_d = 1'b0;
    end else if (phase_q) begin
      count_d = count_q + 32'd1;
    end

    compare_d = compare_q;
    if (bus.compare_wen) begin
      compare_d = bus.cp0_wdata;
    end

    // Writing Compare acknowledges the timer, even on a same-cycle match
    ti_d = ti_q;
    if (bus.compare_wen) begin
      ti_d = 1'b0;
    end else if (count_q == compare_q) begin
      ti_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 6'd0;
      sync2_q   <= 6'd0;
      ip_q      <= 8'd0;
      count_q   <= 32'd0;
      compare_q <= 32'hFFFF_FFFF;
      phase_q   <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      ip_q      <= ip_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      phase_q   <= phase_d;
      ti_q      <= ti_d;
    end
  end

  assign pend = (|(ip_q & bus.status_im)) & bus.status_ie & ~bus.status_exl;

  // Interrupt attaches only to a valid WB instruction without its own exception
  assign take = (state_q == ARMED) & bus.wb_valid & ~bus.wb_exc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (pend) state_q <= ARMED;
        end
        ARMED: begin
          if (take) begin
            state_q <= TAKEN;
          end else if (bus.wb_exc) begin
            // Synchronous exception owns this WB slot; keep waiting
            state_q <= ARMED;
          end else if (!pend) begin
            state_q <= IDLE;
          end
        end
        TAKEN: begin
          // Wait until the handler has raised EXL before re-arming
          if (bus.status_exl) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.count    = count_q;
  assign bus.compare  = compare_q;
  assign bus.ip       = ip_q;
  assign bus.ti       = ti_q;
  assign bus.int_req  = (state_q == ARMED);
  assign bus.int_take = take;

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - directed self-checking bench for int_ctrl
module tb_int_ctrl;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  int_ctrl_if bus ();

  int_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.hw_int      = 6'd0;
    bus.sw_int      = 2'd0;
    bus.status_im   = 8'd0;
    bus.status_ie   = 1'b0;
    bus.status_exl  = 1'b0;
    bus.count_wen   = 1'b0;
    bus.compare_wen = 1'b0;
    bus.cp0_wdata   = 32'd0;
    bus.wb_valid    = 1'b0;
    bus.wb_exc      = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.count !== 32'd0) begin errors++; $display("FAIL reset_count got=%h exp=%h", bus.count, 32'd0); end
    checks++; if (bus.compare !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_compare got=%h exp=%h", bus.compare, 32'hFFFF_FFFF); end
    checks++; if (bus.ti !== 1'b0) begin errors++; $display("FAIL reset_ti got=%b exp=0", bus.ti); end
    checks++; if (bus.ip !== 8'h00) begin errors++; $display("FAIL reset_ip got=%h exp=00", bus.ip); end
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL reset_int_req got=%b exp=0", bus.int_req); end
    checks++; if (bus.int_take !== 1'b0) begin errors++; $display("FAIL reset_int_take got=%b exp=0", bus.int_take); end
    repeat (10) step();
    checks++; if (bus.count !== 32'd5) begin errors++; $display("FAIL idle10_count got=%0d exp=5", bus.count); end
    checks++; if (bus.ti !== 1'b0) begin errors++; $display("FAIL idle10_ti got=%b exp=0", bus.ti); end
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL idle10_int_req got=%b exp=0", bus.int_req); end
  endtask

  task automatic test_sw_int();
    do_reset();
    bus.sw_int = 2'b10;
    step();
    checks++; if (bus.ip !== 8'h02) begin errors++; $display("FAIL sw_int_ip got=%h exp=02", bus.ip); end
    bus.sw_int = 2'b00;
    step();
    checks++; if (bus.ip !== 8'h00) begin errors++; $display("FAIL sw_int_clear got=%h exp=00", bus.ip); end
  endtask

  task automatic test_timer();
    int n;
    do_reset();
    bus.status_im   = 8'h80;
    bus.status_ie   = 1'b1;
    bus.compare_wen = 1'b1;
    bus.cp0_wdata   = 32'd3;
    step();
    bus.compare_wen = 1'b0;
    checks++; if (bus.compare !== 32'd3) begin errors++; $display("FAIL timer_compare got=%0d exp=3", bus.compare); end
    n = 0;
    while (bus.count !== 32'd3 && n < 20) begin
      step();
      n++;
    end
    checks++; if (n != 5) begin errors++; $display("FAIL timer_reach3 cycles got=%0d exp=5", n); end
    checks++; if (bus.ti !== 1'b0) begin errors++; $display("FAIL timer_ti_at_match got=%b exp=0", bus.ti); end
    step();
    checks++; if (bus.ti !== 1'b1) begin errors++; $display("FAIL timer_ti_set got=%b exp=1", bus.ti); end
    checks++; if (bus.ip[7] !== 1'b0) begin errors++; $display("FAIL timer_ip7_early got=%b exp=0", bus.ip[7]); end
    step();
    checks++; if (bus.ip[7] !== 1'b1) begin errors++; $display("FAIL timer_ip7 got=%b exp=1", bus.ip[7]); end
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL timer_req_early got=%b exp=0", bus.int_req); end
    step();
    checks++; if (bus.int_req !== 1'b1) begin errors++; $display("FAIL timer_req got=%b exp=1", bus.int_req); end
    bus.compare_wen = 1'b1;
    bus.cp0_wdata   = 32'd100;
    step();
    bus.compare_wen = 1'b0;
    checks++; if (bus.ti !== 1'b0) begin errors++; $display("FAIL timer_ti_clear got=%b exp=0", bus.ti); end
    step();
    checks++; if (bus.ip[7] !== 1'b0) begin errors++; $display("FAIL timer_ip7_clear got=%b exp=0", bus.ip[7]); end
    step();
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL timer_req_drop got=%b exp=0", bus.int_req); end
  endtask

  task automatic test_hw_int();
    do_reset();
    bus.status_im = 8'h10;
    bus.status_ie = 1'b1;
    bus.hw_int    = 6'b000100;
    step();
    step();
    checks++; if (bus.ip[4] !== 1'b0) begin errors++; $display("FAIL hw_ip4_c2 got=%b exp=0", bus.ip[4]); end
    step();
    checks++; if (bus.ip !== 8'h10) begin errors++; $display("FAIL hw_ip_c3 got=%h exp=10", bus.ip); end
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL hw_req_c3 got=%b exp=0", bus.int_req); end
    step();
    checks++; if (bus.int_req !== 1'b1) begin errors++; $display("FAIL hw_req_c4 got=%b exp=1", bus.int_req); end
    step();
    step();
    bus.wb_valid = 1'b1;
    #1;
    checks++; if (bus.int_take !== 1'b1) begin errors++; $display("FAIL hw_take got=%b exp=1", bus.int_take); end
    step();
    checks++; if (bus.int_take !== 1'b0) begin errors++; $display("FAIL hw_take_pulse got=%b exp=0", bus.int_take); end
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL hw_taken_req got=%b exp=0", bus.int_req); end
    step();
    step();
    checks++; if (bus.int_take !== 1'b0 || bus.int_req !== 1'b0) begin errors++; $display("FAIL hw_taken_hold got=%b%b exp=00", bus.int_take, bus.int_req); end
    bus.wb_valid   = 1'b0;
    bus.status_exl = 1'b1;
    step();
    bus.status_exl = 1'b0;
    step();
    checks++; if (bus.int_req !== 1'b1) begin errors++; $display("FAIL hw_rearm got=%b exp=1", bus.int_req); end
  endtask

  task automatic test_wb_exc();
    bus.wb_valid = 1'b1;
    bus.wb_exc   = 1'b1;
    #1;
    checks++; if (bus.int_take !== 1'b0) begin errors++; $display("FAIL exc_take0 got=%b exp=0", bus.int_take); end
    step();
    checks++; if (bus.int_take !== 1'b0 || bus.int_req !== 1'b1) begin errors++; $display("FAIL exc_hold1 take,req got=%b%b exp=01", bus.int_take, bus.int_req); end
    step();
    checks++; if (bus.int_take !== 1'b0 || bus.int_req !== 1'b1) begin errors++; $display("FAIL exc_hold2 take,req got=%b%b exp=01", bus.int_take, bus.int_req); end
    bus.wb_exc = 1'b0;
    #1;
    checks++; if (bus.int_take !== 1'b1) begin errors++; $display("FAIL exc_release_take got=%b exp=1", bus.int_take); end
    step();
    checks++; if (bus.int_take !== 1'b0) begin errors++; $display("FAIL exc_back_to_back got=%b exp=0", bus.int_take); end
    bus.wb_valid = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    bus.count_wen = 1'b1;
    bus.cp0_wdata = 32'hFFFF_FFFE;
    step();
    bus.count_wen = 1'b0;
    checks++; if (bus.count !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_load got=%h exp=fffffffe", bus.count); end
    bus.compare_wen = 1'b1;
    bus.cp0_wdata   = 32'd0;
    step();
    bus.compare_wen = 1'b0;
    checks++; if (bus.count !== 32'hFFFF_FFFE || bus.compare !== 32'd0) begin errors++; $display("FAIL wrap_c2 count=%h compare=%h exp fffffffe/0", bus.count, bus.compare); end
    step();
    checks++; if (bus.count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_c3 got=%h exp=ffffffff", bus.count); end
    step();
    step();
    checks++; if (bus.count !== 32'd0) begin errors++; $display("FAIL wrap_zero got=%h exp=0", bus.count); end
    checks++; if (bus.ti !== 1'b0) begin errors++; $display("FAIL wrap_ti_early got=%b exp=0", bus.ti); end
    step();
    checks++; if (bus.ti !== 1'b1) begin errors++; $display("FAIL wrap_ti got=%b exp=1", bus.ti); end
    bus.count_wen = 1'b1;
    bus.cp0_wdata = 32'h0000_1234;
    step();
    bus.count_wen = 1'b0;
    checks++; if (bus.count !== 32'h0000_1234) begin errors++; $display("FAIL wrap_load_wins got=%h exp=1234", bus.count); end
    step();
    checks++; if (bus.count !== 32'h0000_1234) begin errors++; $display("FAIL wrap_phase_clr got=%h exp=1234", bus.count); end
    step();
    checks++; if (bus.count !== 32'h0000_1235) begin errors++; $display("FAIL wrap_inc got=%h exp=1235", bus.count); end
    checks++; if (bus.ti !== 1'b1) begin errors++; $display("FAIL wrap_ti_sticky got=%b exp=1", bus.ti); end
  endtask

  task automatic test_reset_armed();
    bus.status_im = 8'h80;
    bus.status_ie = 1'b1;
    step();
    checks++; if (bus.int_req !== 1'b1 || bus.ti !== 1'b1) begin errors++; $display("FAIL rst_pre req,ti got=%b%b exp=11", bus.int_req, bus.ti); end
    reset           = 1'b1;
    bus.compare_wen = 1'b1;
    bus.count_wen   = 1'b1;
    bus.cp0_wdata   = 32'd7;
    bus.wb_valid    = 1'b1;
    step();
    checks++; if (bus.int_req !== 1'b0) begin errors++; $display("FAIL rst_int_req got=%b exp=0", bus.int_req); end
    checks++; if (bus.ti !== 1'b0) begin errors++; $display("FAIL rst_ti got=%b exp=0", bus.ti); end
    checks++; if (bus.compare !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_compare got=%h exp=ffffffff", bus.compare); end
    checks++; if (bus.count !== 32'd0) begin errors++; $display("FAIL rst_count got=%h exp=0", bus.count); end
    checks++; if (bus.ip !== 8'h00 || bus.int_take !== 1'b0) begin errors++; $display("FAIL rst_ip_take ip=%h take=%b exp 00/0", bus.ip, bus.int_take); end
    reset = 1'b0;
    clear_inputs();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    clear_inputs();
    test_reset();
    test_sw_int();
    test_timer();
    test_hw_int();
    test_wb_exc();
    test_wrap();
    test_reset_armed();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
